// File: rtl/pipe_skid_reg.sv
// One-stage valid/ready pipeline register with a one-entry skid buffer.
// All outputs decode from registered state, so ready_in never reaches ready_out combinationally.
module pipe_skid_reg #(
  parameter int unsigned             DATA_WIDTH  = 32,
  parameter logic [DATA_WIDTH-1:0]   RESET_VALUE = '0
) (
  input  logic                  clock_in,
  input  logic                  reset_in,
  input  logic                  flush_in,
  input  logic                  valid_in,
  output logic                  ready_out,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  valid_out,
  input  logic                  ready_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [1:0]            occupancy_out
);

  // Encoding doubles as the entry count.
  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StFull  = 2'd2
  } state_e;

  state_e                state_q;
  logic [DATA_WIDTH-1:0] main_q;
  logic [DATA_WIDTH-1:0] skid_q;
  logic                  in_fire;
  logic                  out_fire;

  assign valid_out     = (state_q != StEmpty);
  assign ready_out     = (state_q != StFull);
  assign occupancy_out = state_q;
  assign data_out      = main_q;

  assign in_fire  = valid_in & ready_out;
  assign out_fire = valid_out & ready_in;

  always_ff @(posedge clock_in) begin
    if (reset_in || flush_in) begin
      // Flush squashes everything held, including any payload arriving this cycle.
      state_q <= StEmpty;
      main_q  <= RESET_VALUE;
      skid_q  <= RESET_VALUE;
    end else begin
      case (state_q)
        StEmpty: begin
          if (in_fire) begin
            main_q  <= data_in;
            state_q <= StOne;
          end
        end
        StOne: begin
          if (in_fire && out_fire) begin
            main_q <= data_in;
          end else if (in_fire) begin
            skid_q  <= data_in;
            state_q <= StFull;
          end else if (out_fire) begin
            state_q <= StEmpty;
          end
        end
        StFull: begin
          if (out_fire) begin
            main_q  <= skid_q;
            state_q <= StOne;
          end
        end
        default: state_q <= StEmpty;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Self-checking bench for pipe_skid_reg: directed scenarios plus a randomised
// scoreboard run comparing delivered payloads against a FIFO model.
module tb_pipe_skid_reg;

  localparam int unsigned     DW   = 32;
  localparam logic [DW-1:0]   RVAL = 32'hC0DE_0001;

  logic          clock;
  logic          reset_in;
  logic          flush_in;
  logic          valid_in;
  logic          ready_out;
  logic [DW-1:0] data_in;
  logic          valid_out;
  logic          ready_in;
  logic [DW-1:0] data_out;
  logic [1:0]    occupancy_out;

  int n_vec;
  int n_err;
  bit mon_en;

  logic [DW-1:0] sb_q[$];
  logic          prev_stall;
  logic [DW-1:0] prev_data;

  pipe_skid_reg #(
    .DATA_WIDTH  (DW),
    .RESET_VALUE (RVAL)
  ) dut (
    .clock_in      (clock),
    .reset_in      (reset_in),
    .flush_in      (flush_in),
    .valid_in      (valid_in),
    .ready_out     (ready_out),
    .data_in       (data_in),
    .valid_out     (valid_out),
    .ready_in      (ready_in),
    .data_out      (data_out),
    .occupancy_out (occupancy_out)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check_eq(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Advance one clock; inputs are then driven and outputs sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Scoreboard and invariants, sampled mid-cycle where the upcoming edge's fires are known.
  always @(negedge clock) begin
    if (mon_en) begin
      check_eq("occ_model", {30'd0, occupancy_out}, sb_q.size());
      check_eq("ready_model", {31'd0, ready_out}, {31'd0, (sb_q.size() < 2)});
      check_eq("valid_model", {31'd0, valid_out}, {31'd0, (sb_q.size() != 0)});
      if (prev_stall) check_eq("stall_stable", data_out, prev_data);
      if (valid_out && ready_in) begin
        if (sb_q.size() == 0) check_eq("pop_empty", 32'd0, 32'd1);
        else check_eq("sb_data", data_out, sb_q.pop_front());
      end
    end
    if (reset_in || flush_in) sb_q.delete();
    else if (valid_in && ready_out) sb_q.push_back(data_in);
    prev_stall = valid_out && !ready_in && !reset_in && !flush_in;
    prev_data  = data_out;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic fill_full(input logic [DW-1:0] a, input logic [DW-1:0] b);
    ready_in = 1'b0;
    valid_in = 1'b1;
    data_in  = a;
    step();
    data_in  = b;
    step();
    valid_in = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_valid"}, {31'd0, valid_out}, 32'd0);
    check_eq({tag, "_ready"}, {31'd0, ready_out}, 32'd1);
    check_eq({tag, "_occ"}, {30'd0, occupancy_out}, 32'd0);
    check_eq({tag, "_data"}, data_out, RVAL);
  endtask

  initial begin
    n_vec      = 0;
    n_err      = 0;
    mon_en     = 1'b0;
    prev_stall = 1'b0;
    prev_data  = '0;
    reset_in   = 1'b1;
    flush_in   = 1'b0;
    valid_in   = 1'b0;
    ready_in   = 1'b0;
    data_in    = '0;
    step();
    step();
    reset_in = 1'b0;
    mon_en   = 1'b1;
    check_reset_outputs("reset");

    // Single transfer, 1-cycle latency
    valid_in = 1'b1;
    ready_in = 1'b1;
    data_in  = 32'hA5A5_A5A5;
    step();
    valid_in = 1'b0;
    check_eq("single_valid", {31'd0, valid_out}, 32'd1);
    check_eq("single_data", data_out, 32'hA5A5_A5A5);
    check_eq("single_occ", {30'd0, occupancy_out}, 32'd1);
    step();
    check_eq("single_drain", {31'd0, valid_out}, 32'd0);

    // Full-throughput streaming
    valid_in = 1'b1;
    data_in  = 32'd1;
    for (int i = 1; i <= 16; i++) begin
      step();
      check_eq("stream_data", data_out, i);
      check_eq("stream_occ", {30'd0, occupancy_out}, 32'd1);
      check_eq("stream_ready", {31'd0, ready_out}, 32'd1);
      data_in = i + 1;
      if (i == 16) valid_in = 1'b0;
    end
    step();
    check_eq("stream_end", {31'd0, valid_out}, 32'd0);

    // Back-pressure into the skid entry
    fill_full(32'h11, 32'h22);
    check_eq("bp_occ", {30'd0, occupancy_out}, 32'd2);
    check_eq("bp_ready", {31'd0, ready_out}, 32'd0);
    check_eq("bp_data", data_out, 32'h11);
    step();
    check_eq("bp_hold", data_out, 32'h11);
    ready_in = 1'b1;
    step();
    check_eq("bp_second", data_out, 32'h22);
    check_eq("bp_ready_back", {31'd0, ready_out}, 32'd1);
    check_eq("bp_occ_one", {30'd0, occupancy_out}, 32'd1);
    step();
    check_eq("bp_empty", {31'd0, valid_out}, 32'd0);

    // Flush while full, with an offered payload
    fill_full(32'h44, 32'h55);
    valid_in = 1'b1;
    data_in  = 32'h33;
    flush_in = 1'b1;
    step();
    flush_in = 1'b0;
    valid_in = 1'b0;
    check_reset_outputs("flush_full");

    // Flush while one entry held, coinciding with in_fire and out_fire
    valid_in = 1'b1;
    data_in  = 32'h66;
    ready_in = 1'b0;
    step();
    data_in  = 32'h33;
    ready_in = 1'b1;
    flush_in = 1'b1;
    step();
    flush_in = 1'b0;
    valid_in = 1'b0;
    check_reset_outputs("flush_one");
    step();
    check_eq("flush_no_33", {31'd0, valid_out}, 32'd0);

    // Reset mid-stream while full: no effect until the clock edge
    fill_full(32'h77, 32'h88);
    reset_in = 1'b1;
    #3;
    check_eq("rst_sync_occ", {30'd0, occupancy_out}, 32'd2);
    check_eq("rst_sync_data", data_out, 32'h77);
    step();
    reset_in = 1'b0;
    check_reset_outputs("rst_full");

    // Random traffic against the scoreboard
    for (int c = 0; c < 10000; c++) begin
      valid_in = ($urandom_range(0, 3) != 0);
      ready_in = ($urandom_range(0, 2) != 0);
      data_in  = $urandom;
      flush_in = ($urandom_range(0, 127) == 0);
      step();
    end
    valid_in = 1'b0;
    flush_in = 1'b0;
    ready_in = 1'b1;
    step();
    step();
    step();
    check_eq("drain_sb", sb_q.size(), 32'd0);
    check_eq("drain_valid", {31'd0, valid_out}, 32'd0);

    @(negedge clock);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
